bcd_result_converter: RTL and testbench

Sequential binary-to-BCD converter that sits directly downstream of the calculator ALU. It captures the 40-bit result, either the sum/difference or the low product/quotient word, when the ALU signals completion. It then converts the value to 13 packed BCD digits using a shift-and-add-3 (double-dabble) iteration, one bit per clock, and presents the digits to the display driver with a one-cycle valid strobe.

---
 rtl/bcd_result_converter_pkg.sv | 15 +
 rtl/bcd_result_converter_if.sv | 14 +
 rtl/bcd_add3_digit.sv | 7 +
 rtl/bcd_result_converter.sv | 105 ++++++++++
 tb/tb_bcd_result_converter.sv | 132 +++++++++++++
 5 files changed

// File: rtl/bcd_result_converter_pkg.sv
// Shared constants and state encoding for the ALU result BCD converter.
// The optional signed mode (BCD_SIGNED_RESULT_EN) lives in the top module.
package calc_pkg;

    localparam int WIDTH  = 40;
    localparam int DIGITS = 13;
    localparam int CNT_W  = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_e;

endpackage

// File: rtl/bcd_result_converter_if.sv
// ALU-to-converter-to-display bundle: capture request and value in, BCD result and status out.
interface bcd_result_converter_if;
    import calc_pkg::*;

    logic                  START;
    logic [WIDTH-1:0]      BIN;
    logic [4*DIGITS-1:0]   BCD;
    logic                  NEG;
    logic                  BUSY;
    logic                  VALID;

    modport master (output START, output BIN, input BCD, input NEG, input BUSY, input VALID);
    modport slave  (input START, input BIN, output BCD, output NEG, output BUSY, output VALID);
endinterface

// File: rtl/bcd_add3_digit.sv
// Double-dabble digit correction: a digit of 5 or more gets 3 added before the shift.
module bcd_add3_digit (
    input  logic [3:0] d_i,
    output logic [3:0] d_o
);
    assign d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;
endmodule

// File: rtl/bcd_result_converter.sv
// Sequential binary-to-BCD converter, one bit per clock, with a one-cycle VALID strobe.
// Define BCD_SIGNED_RESULT_EN to treat BIN as two's complement and report the sign on NEG.
module bcd_result_converter
    import calc_pkg::*;
(
    input  logic                   CLK,
    input  logic                   RST,
    bcd_result_converter_if.slave  cv
);

    conv_state_e            state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [WIDTH-1:0]       sreg_q;
    logic [4*DIGITS-1:0]    acc_q;
    logic [4*DIGITS-1:0]    bcd_q;
    logic                   busy_q;
    logic                   valid_q;

    logic [4*DIGITS-1:0]    corr;
    logic [4*DIGITS-1:0]    acc_d;
    logic [WIDTH-1:0]       mag_d;

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        bcd_add3_digit u_add3 (
            .d_i (acc_q[4*g +: 4]),
            .d_o (corr[4*g +: 4])
        );
    end

    // The top corrected bit never carries out for these sizes, so truncation is safe.
    assign acc_d = (4*DIGITS)'({corr, sreg_q[WIDTH-1]});

`ifdef BCD_SIGNED_RESULT_EN
    logic sign_q;
    logic neg_q;

    assign mag_d = cv.BIN[WIDTH-1] ? (~cv.BIN) + WIDTH'(1) : cv.BIN;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sign_q <= 1'b0;
            neg_q  <= 1'b0;
        end else if (state_q == IDLE && cv.START) begin
            sign_q <= cv.BIN[WIDTH-1];
        end else if (state_q == SHIFT && cnt_q == CNT_W'(1)) begin
            neg_q  <= sign_q;
        end
    end

    assign cv.NEG = neg_q;
`else
    assign mag_d  = cv.BIN;
    assign cv.NEG = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sreg_q  <= '0;
            acc_q   <= '0;
            bcd_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    valid_q <= 1'b0;
                    if (cv.START) begin
                        sreg_q  <= mag_d;
                        acc_q   <= '0;
                        cnt_q   <= CNT_W'(WIDTH);
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc_q  <= acc_d;
                    sreg_q <= sreg_q << 1;
                    cnt_q  <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        bcd_q   <= acc_d;
                        valid_q <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cv.BCD   = bcd_q;
    assign cv.BUSY  = busy_q;
    assign cv.VALID = valid_q;

endmodule

// File: tb/tb_bcd_result_converter.sv
// Directed-vector bench for bcd_result_converter; expectations follow BCD_SIGNED_RESULT_EN.
module tb_bcd_result_converter;
    import calc_pkg::*;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    bcd_result_converter_if cv ();

    bcd_result_converter dut (
        .CLK (CLK),
        .RST (RST),
        .cv  (cv.slave)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Counts edges after the accept edge until VALID is seen; returns the count (0 on timeout).
    task automatic wait_valid(output int k);
        k = 0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge CLK); #1;
            if (cv.VALID) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic convert(input string tag, input logic [WIDTH-1:0] bin,
                           input logic [63:0] exp_bcd, input logic exp_neg);
        int k;
        logic [63:0] prev;
        prev = 64'(cv.BCD);
        @(negedge CLK);
        cv.BIN   = bin;
        cv.START = 1'b1;
        @(posedge CLK); #1;
        cv.START = 1'b0;
        cv.BIN   = ~bin;
        chk({tag, ".busy_set"}, 64'(cv.BUSY), 64'd1);
        chk({tag, ".bcd_held"}, 64'(cv.BCD), prev);
        wait_valid(k);
        chk({tag, ".latency"}, 64'(k), 64'd40);
        chk({tag, ".bcd"}, 64'(cv.BCD), exp_bcd);
        chk({tag, ".neg"}, 64'(cv.NEG), 64'(exp_neg));
        chk({tag, ".busy_done"}, 64'(cv.BUSY), 64'd1);
        @(posedge CLK); #1;
        chk({tag, ".valid_1cyc"}, 64'(cv.VALID), 64'd0);
        chk({tag, ".busy_fall"}, 64'(cv.BUSY), 64'd0);
    endtask

    initial begin
        int k;
        int nvalid;
        cv.START = 1'b0;
        cv.BIN   = '0;
        #12;
        chk("rst.bcd",   64'(cv.BCD),   64'd0);
        chk("rst.neg",   64'(cv.NEG),   64'd0);
        chk("rst.busy",  64'(cv.BUSY),  64'd0);
        chk("rst.valid", 64'(cv.VALID), 64'd0);
        @(negedge CLK);
        RST = 1'b0;

        convert("zero",  40'd0,     64'h0, 1'b0);
        convert("12345", 40'd12345, 64'h0000000012345, 1'b0);
        convert("99",    40'd99,    64'h99, 1'b0);
`ifdef BCD_SIGNED_RESULT_EN
        convert("allones", 40'hFF_FFFF_FFFF, 64'h1, 1'b1);
        convert("mostneg", 40'h80_0000_0000, 64'h0549755813888, 1'b1);
        convert("pos_after_neg", 40'd7, 64'h7, 1'b0);
`else
        convert("allones", 40'hFF_FFFF_FFFF, 64'h1099511627775, 1'b0);
        convert("msb",     40'h80_0000_0000, 64'h0549755813888, 1'b0);
`endif

        // START held through a conversion while BIN changes: one capture, re-accept at n+42.
        @(negedge CLK);
        cv.BIN   = 40'd4321;
        cv.START = 1'b1;
        @(posedge CLK); #1;
        cv.BIN = 40'd8765;
        wait_valid(k);
        chk("hold.latency", 64'(k), 64'd40);
        chk("hold.bcd", 64'(cv.BCD), 64'h4321);
        @(posedge CLK); #1;
        chk("hold.idle_busy", 64'(cv.BUSY), 64'd0);
        @(posedge CLK); #1;
        chk("hold.reaccept", 64'(cv.BUSY), 64'd1);
        cv.START = 1'b0;
        wait_valid(k);
        chk("hold2.latency", 64'(k), 64'd40);
        chk("hold2.bcd", 64'(cv.BCD), 64'h8765);

        // Reset mid-conversion discards the partial result.
        @(negedge CLK);
        cv.BIN   = 40'd555;
        cv.START = 1'b1;
        @(posedge CLK); #1;
        cv.START = 1'b0;
        repeat (20) @(posedge CLK);
        #1 RST = 1'b1;
        #2;
        chk("midrst.busy",  64'(cv.BUSY),  64'd0);
        chk("midrst.valid", 64'(cv.VALID), 64'd0);
        chk("midrst.bcd",   64'(cv.BCD),   64'd0);
        @(negedge CLK);
        RST = 1'b0;
        nvalid = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (cv.VALID) nvalid++;
        end
        chk("midrst.no_valid", 64'(nvalid), 64'd0);
        convert("after_rst", 40'd1000000, 64'h1000000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
